aes256_inv_round_ctrl: RTL and testbench
========================================

Name: aes256_inv_round_ctrl

Overview:
Iterative AES-256 decryption sequencer. It accepts one 128-bit ciphertext block and runs the initial AddRoundKey, 13 full inverse rounds and the final inverse round, one round per clock, on a single shared inverse-round datapath built around InverseSubByte. It fetches round keys 14..0 from the external synchronous-read round-key store, which the key-expansion block fills, and returns the 128-bit plaintext over a valid/ready handshake.

Parameters:
NR, 14, number of rounds (AES-256); round-key index range is 0..NR.
RKA_W, 4, round-key address width; must satisfy 2**RKA_W > NR.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  ciphertext present.
in_ready  output  1  controller can accept a block (high only in IDLE).
data_in  input  128  ciphertext, byte 0 in [127:120].
rk_addr  output  RKA_W  round-key read address to the key store.
rk_data  input  128  round key; valid 1 cycle after rk_addr is sampled.
key_lock  output  1  high while a block is in flight; the key store must not be rewritten.
out_valid  output  1  plaintext valid.
out_ready  input  1  consumer accepts the plaintext.
data_out  output  128  plaintext, registered.

Behaviour:
- Reset values: in_ready=0 during rst and 1 from the first cycle after; out_valid=0, key_lock=0, rk_addr=0, data_out=0, state reg=0, round counter=0, FSM=IDLE.
- FSM states: IDLE, FETCH, INIT, ROUND, FINAL, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, capture data_in into the state register, set rk_addr<=NR, set key_lock<=1, go to FETCH.
- FETCH: rk_addr<=NR-1, go to INIT. During this cycle the key store samples address NR.
- INIT: state <= state ^ rk_data (rk[14]), rk_addr<=NR-2, round cnt<=NR-1, go to ROUND.
- ROUND (13 cycles, cnt 13 down to 1): state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_data).
  - rk_addr decrements each cycle and saturates at 0.
  - When cnt==1, go to FINAL; otherwise cnt<=cnt-1.
- FINAL: data_out <= InvSubBytes(InvShiftRows(state)) ^ rk_data (rk[0]), out_valid<=1, go to DONE.
- DONE: hold data_out and out_valid until out_valid&out_ready. On that cycle: out_valid<=0, key_lock<=0, go to IDLE.
- Latency: accept at cycle T gives out_valid first high at T+17. Throughput is at most one block per 18 cycles (the 17-cycle latency plus the IDLE cycle needed before the next accept).
- in_valid while not in IDLE is ignored; data_in is not sampled.
- out_ready while out_valid=0 is ignored.
- rk_data is sampled only in INIT, ROUND and FINAL; its value in other states is don't-care.
- rst in any state, including mid-round or DONE, returns all outputs to reset values on the next edge. A partial result is never presented.
- Both out_valid and in_ready are never high in the same cycle.

Decomposition:
- Shared package (aes_pkg): constant NR=14, constant NB_BITS=128, FSM state encoding, and an InvMixColumns function with its GF(2^8) xtime helper.
- One sub-module: aes_inv_round, purely combinational.
  - Inputs: state, rk, last flag.
  - Operation: InvShiftRows, then InverseSubByte, then XOR with rk, then InvMixColumns bypassed when last=1.
  - This controller instantiates it once and muxes last=(FSM==FINAL).

Test Plan:
- FIPS-197 C.3 vector: key store preloaded with the expansion of key 000102..1f; data_in=8ea2b7ca516745bfeafc49904b496089; out_ready=1. Required: data_out=00112233445566778899aabbccddeeff with out_valid high exactly 17 cycles after accept.
- rk_addr trace for that block: NR in FETCH, then 13,12,...,0 over INIT..last ROUND. Each value is held one cycle and rk_addr never underflows.
- Backpressure: out_ready=0 for 10 cycles after out_valid. Required: data_out and out_valid stable, in_ready=0, key_lock=1. Then out_ready=1 for 1 cycle gives IDLE next cycle.
- Back-to-back: in_valid held high with two different ciphertexts. Required: the second is accepted only in the cycle after the first handshake completes, and both plaintexts are correct.
- Reset mid-operation: assert rst at ROUND cnt=7. Required: the next cycle has out_valid=0, key_lock=0, in_ready=0, and in_ready=1 the cycle after rst drops. A new vector then decrypts correctly.
- Ignored input: in_valid pulses with garbage data during ROUND. Required: no effect on the result.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants, controller state encoding and GF(2^8) helpers for the
// iterative AES-256 decryption datapath.
package aes_pkg;

  localparam int NR      = 14;
  localparam int NB_BITS = 128;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_INIT  = 3'd2,
    ST_ROUND = 3'd3,
    ST_FINAL = 3'd4,
    ST_DONE  = 3'd5
  } ctrl_state_e;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply by shift-and-add.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  // InverseSubByte: undo the affine transform, then invert in the field.
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] b;
    b = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  // InvMixColumns on one column, byte 0 in the top bits.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0]  a  [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      a[i]  = w[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
    end
    // Row i: 0e*a[i] ^ 0b*a[i+1] ^ 0d*a[i+2] ^ 09*a[i+3]
    for (int i = 0; i < 4; i++) begin
      r[31-8*i -: 8] = (x8[i] ^ x4[i] ^ x2[i])
                     ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4])
                     ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])
                     ^ (x8[(i+3)%4] ^ a[(i+3)%4]);
    end
    return r;
  endfunction

  function automatic logic [NB_BITS-1:0] inv_mix_columns(input logic [NB_BITS-1:0] s);
    logic [NB_BITS-1:0] r;
    for (int c = 0; c < 4; c++) begin
      r[NB_BITS-1-32*c -: 32] = inv_mix_col(s[NB_BITS-1-32*c -: 32]);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [NB_BITS-1:0] state,
  input  logic [NB_BITS-1:0] rk,
  input  logic               last,
  output logic [NB_BITS-1:0] result
);

  logic [NB_BITS-1:0] sub_bytes;
  logic [NB_BITS-1:0] add_key;

  // Byte i sits at row i%4, column i/4; InvShiftRows moves row r right by r,
  // so output (r,c) takes input (r,(c-r) mod 4).
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_byte
      localparam int ROW = gi % 4;
      localparam int COL = gi / 4;
      localparam int SRC = ((COL - ROW + 4) % 4) * 4 + ROW;
      assign sub_bytes[NB_BITS-1-8*gi -: 8] = inv_sbox(state[NB_BITS-1-8*SRC -: 8]);
    end
  endgenerate

  assign add_key = sub_bytes ^ rk;
  assign result  = last ? add_key : inv_mix_columns(add_key);

endmodule

// File: rtl/aes256_inv_round_ctrl.sv
// Iterative AES-256 decryption sequencer: one inverse round per clock on a
// shared datapath, round keys fetched 14..0 from a synchronous-read key store.
module aes256_inv_round_ctrl #(
  parameter int NR    = 14,
  parameter int RKA_W = 4    // must satisfy 2**RKA_W > NR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     data_in,
  output logic [RKA_W-1:0] rk_addr,
  input  logic [127:0]     rk_data,
  output logic             key_lock,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     data_out
);

  import aes_pkg::*;

  ctrl_state_e        fsm_reg, fsm_next;
  logic [127:0]       state_reg, state_next;
  logic [RKA_W-1:0]   cnt_reg, cnt_next;
  logic [RKA_W-1:0]   rk_addr_reg, rk_addr_next;
  logic               key_lock_reg, key_lock_next;
  logic               out_valid_reg, out_valid_next;
  logic               in_ready_reg, in_ready_next;
  logic [127:0]       data_out_reg, data_out_next;
  logic [NB_BITS-1:0] round_out;
  logic               last_round;

  assign last_round = (fsm_reg == ST_FINAL);

  aes_inv_round u_round (
    .state  (state_reg),
    .rk     (rk_data),
    .last   (last_round),
    .result (round_out)
  );

  // Next-state and datapath control; the key address runs one step ahead of
  // the round that consumes it because the key store has one cycle of latency.
  always_comb begin
    fsm_next       = fsm_reg;
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    rk_addr_next   = rk_addr_reg;
    key_lock_next  = key_lock_reg;
    out_valid_next = out_valid_reg;
    data_out_next  = data_out_reg;
    in_ready_next  = 1'b0;
    case (fsm_reg)
      ST_IDLE: begin
        in_ready_next = 1'b1;
        if (in_valid && in_ready_reg) begin
          state_next    = data_in;
          rk_addr_next  = RKA_W'(NR);
          key_lock_next = 1'b1;
          in_ready_next = 1'b0;
          fsm_next      = ST_FETCH;
        end
      end
      ST_FETCH: begin
        rk_addr_next = RKA_W'(NR - 1);
        fsm_next     = ST_INIT;
      end
      ST_INIT: begin
        state_next   = state_reg ^ rk_data;
        rk_addr_next = RKA_W'(NR - 2);
        cnt_next     = RKA_W'(NR - 1);
        fsm_next     = ST_ROUND;
      end
      ST_ROUND: begin
        state_next = round_out;
        if (rk_addr_reg != '0) rk_addr_next = rk_addr_reg - RKA_W'(1);
        if (cnt_reg == RKA_W'(1)) fsm_next = ST_FINAL;
        else                      cnt_next = cnt_reg - RKA_W'(1);
      end
      ST_FINAL: begin
        data_out_next  = round_out;
        out_valid_next = 1'b1;
        fsm_next       = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          key_lock_next  = 1'b0;
          in_ready_next  = 1'b1;
          fsm_next       = ST_IDLE;
        end
      end
      default: fsm_next = ST_IDLE;
    endcase
  end

  // State register; reset drops any block in flight without presenting it.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_reg       <= ST_IDLE;
      state_reg     <= '0;
      cnt_reg       <= '0;
      rk_addr_reg   <= '0;
      key_lock_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b0;
      data_out_reg  <= '0;
    end else begin
      fsm_reg       <= fsm_next;
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      rk_addr_reg   <= rk_addr_next;
      key_lock_reg  <= key_lock_next;
      out_valid_reg <= out_valid_next;
      in_ready_reg  <= in_ready_next;
      data_out_reg  <= data_out_next;
    end
  end

  assign in_ready  = in_ready_reg;
  assign rk_addr   = rk_addr_reg;
  assign key_lock  = key_lock_reg;
  assign out_valid = out_valid_reg;
  assign data_out  = data_out_reg;

endmodule

// File: tb/tb_aes256_inv_round_ctrl.sv
// Bench for the AES-256 decryption sequencer: plaintexts are encrypted by a
// forward AES model here, the DUT must return them; timing per cycle.
module tb_aes256_inv_round_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] data_in = '0;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data = '0;
  logic         key_lock;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] data_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  aes256_inv_round_ctrl #(.NR(14), .RKA_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .rk_addr   (rk_addr),
    .rk_data   (rk_data),
    .key_lock  (key_lock),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
  );

  // Key store: synchronous read, one cycle latency.
  logic [127:0] rk_mem [16];
  always @(posedge clk) rk_data <= rk_mem[rk_addr];

  logic [7:0] sbox [256];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = sbox[s[127-8*(r+4*((c+r)%4)) -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
                           a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
                           a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
                           gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
    end
    return o;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk_mem[0];
    for (int r = 1; r <= 14; r++) begin
      s = sub_shift(s);
      if (r != 14) s = mix(s);
      s = s ^ rk_mem[r];
    end
    return s;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
  endfunction

  task automatic set_key(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    rk_mem[15] = '0;
  endtask

  // Behavioural model: a block accepted at cycle T is busy for 17 cycles,
  // presents rk addresses 14..0 at T+1..T+15, and shows its plaintext from T+17.
  logic         rst_q = 1'b1;
  int           m_busy = 0;
  int           m_age = 0;
  logic [127:0] m_exp = '0;
  logic [127:0] cur_pt = '0;
  int           n_done = 0;

  always @(posedge clk) rst_q <= rst;

  always @(negedge clk) begin
    if (rst_q) begin
      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_key_lock", 128'(key_lock), 128'd0);
      chk("rst_in_ready", 128'(in_ready), 128'd0);
      chk("rst_rk_addr", 128'(rk_addr), 128'd0);
      chk("rst_data_out", data_out, 128'd0);
      m_busy = 0;
    end else if (m_busy == 0) begin
      chk("idle_in_ready", 128'(in_ready), 128'd1);
      chk("idle_out_valid", 128'(out_valid), 128'd0);
      chk("idle_key_lock", 128'(key_lock), 128'd0);
      if (in_valid && !rst) begin
        m_busy = 1;
        m_age = 0;
        m_exp = cur_pt;
      end
    end else begin
      m_age++;
      chk("busy_in_ready", 128'(in_ready), 128'd0);
      chk("busy_key_lock", 128'(key_lock), 128'd1);
      if (m_age <= 15) chk("rk_addr", 128'(rk_addr), 128'(15 - m_age));
      if (m_age <= 16) begin
        chk("latency_out_valid", 128'(out_valid), 128'd0);
      end else begin
        chk("done_out_valid", 128'(out_valid), 128'd1);
        chk("data_out", data_out, m_exp);
        if (out_ready && !rst) begin
          n_done++;
          $display("txn %0d plaintext=%h cycles_in_done=%0d", n_done, data_out, m_age - 16);
          m_busy = 0;
        end
      end
    end
  end

  task automatic send(input logic [127:0] ct, input logic [127:0] pt, input bit keep);
    bit got;
    got = 1'b0;
    data_in = ct;
    cur_pt = pt;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (in_ready && !rst) got = 1'b1;
    end
    chk("accept_timeout", 128'(got), 128'd1);
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  // Hold out_ready low for 'stall' (>=1) cycles of out_valid, then accept.
  task automatic drain(input int stall);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("out_valid_timeout", 128'(seen), 128'd1);
    repeat (stall) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 400 && n_done < target; i++) @(posedge clk);
    chk("done_count", 128'(n_done), 128'(target));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]   inv;
    logic [7:0]   idx;
    logic [127:0] pt;
    logic [127:0] pt2;
    int           stall;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    idx = 8'h00;
    chk("pin_sbox_00", 128'(sbox[idx]), 128'h63);
    idx = 8'h53;
    chk("pin_sbox_53", 128'(sbox[idx]), 128'hed);
    set_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    chk("pin_rk1", rk_mem[1], 128'h101112131415161718191a1b1c1d1e1f);
    chk("pin_fips_enc", aes_enc(128'h00112233445566778899aabbccddeeff),
        128'h8ea2b7ca516745bfeafc49904b496089);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // FIPS-197 C.3 vector
    send(128'h8ea2b7ca516745bfeafc49904b496089, 128'h00112233445566778899aabbccddeeff, 1'b0);
    wait_done(1);

    // Backpressure: 10 stalled cycles
    pt = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b0;
    send(aes_enc(pt), pt, 1'b0);
    drain(10);
    wait_done(2);

    // Back-to-back with in_valid held high
    pt = {$urandom, $urandom, $urandom, $urandom};
    pt2 = {$urandom, $urandom, $urandom, $urandom};
    send(aes_enc(pt), pt, 1'b1);
    send(aes_enc(pt2), pt2, 1'b0);
    wait_done(4);

    // Reset during ROUND with cnt=7, then a fresh block
    pt = {$urandom, $urandom, $urandom, $urandom};
    send(aes_enc(pt), pt, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    pt = {$urandom, $urandom, $urandom, $urandom};
    send(aes_enc(pt), pt, 1'b0);
    wait_done(5);

    // Garbage in_valid pulses while busy
    pt = {$urandom, $urandom, $urandom, $urandom};
    send(aes_enc(pt), pt, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    in_valid = 1'b1;
    data_in = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    #1;
    data_in = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_done(6);

    // Randomized blocks, keys and stalls
    for (int i = 0; i < 8; i++) begin
      if (i % 3 == 0)
        set_key({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      pt = {$urandom, $urandom, $urandom, $urandom};
      stall = int'($urandom_range(0, 4));
      out_ready = (stall == 0);
      send(aes_enc(pt), pt, 1'b0);
      if (stall > 0) drain(stall);
      wait_done(7 + i);
    end

    chk("total_blocks", 128'(n_done), 128'd14);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
